// File: rtl/alu_4bit_reg.sv
// ============================================================================
// Module   : alu_4bit_reg
// Purpose  : Registered WIDTH-bit ALU, 3-bit opcode, 2*WIDTH zero-extended result
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_4bit_reg #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         sel,
  output logic [2*WIDTH-1:0] result,
  output logic               out_valid,
  output logic               zero,
  output logic               carry
);

  localparam int RW = 2 * WIDTH;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_SHL = 3'b010;
  localparam logic [2:0] c_OP_AND = 3'b011;
  localparam logic [2:0] c_OP_OR  = 3'b100;
  localparam logic [2:0] c_OP_NOT = 3'b101;
  localparam logic [2:0] c_OP_XOR = 3'b110;
  localparam logic [2:0] c_OP_SHR = 3'b111;

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [RW-1:0] result_d;
  logic          carry_d;

  logic [RW-1:0] result_q;
  logic          valid_q;
  logic          zero_q;
  logic          carry_q;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    case (sel)
      c_OP_ADD: begin
        result_d = a_ext + b_ext;
        carry_d  = result_d[WIDTH];
      end
      c_OP_SUB: begin
        // Wraps modulo 2^RW; borrow is simply the unsigned compare.
        result_d = a_ext - b_ext;
        carry_d  = (a < b);
      end
      c_OP_SHL: result_d = a_ext << 1;
      c_OP_AND: result_d = a_ext & b_ext;
      c_OP_OR:  result_d = a_ext | b_ext;
      c_OP_NOT: result_d = {{WIDTH{1'b0}}, ~a};
      c_OP_XOR: result_d = a_ext ^ b_ext;
      c_OP_SHR: result_d = b_ext >> 1;
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        zero_q   <= (result_d == '0);
        carry_q  <= carry_d;
      end
    end
  end

  assign result    = result_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_4bit_reg.sv
// ============================================================================
// Module   : tb_alu_4bit_reg
// Purpose  : Scoreboard bench for alu_4bit_reg against an arithmetic reference
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_4bit_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] sel;
  logic [7:0] result;
  logic       out_valid;
  logic       zero;
  logic       carry;

  alu_4bit_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero),
    .carry     (carry)
  );

  typedef struct {
    int res;
    int z;
    int c;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operand values.
  function automatic exp_t model(input int av, input int bv, input int s);
    exp_t e;
    int   r;
    int   c;
    c = 0;
    case (s)
      0: begin r = av + bv; c = (r > 15) ? 1 : 0; end
      1: begin r = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0; end
      2: r = av * 2;
      3: r = av & bv;
      4: r = av | bv;
      5: r = 15 - av;
      6: r = av ^ bv;
      default: r = bv / 2;
    endcase
    e.res = r;
    e.z   = (r == 0) ? 1 : 0;
    e.c   = c;
    e.due = 0;
    return e;
  endfunction

  task automatic issue(input int av, input int bv, input int s);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = av[3:0];
    b        = bv[3:0];
    sel      = s[2:0];
    e        = model(av, bv, s);
    e.due    = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 4'($urandom);
      b        = 4'($urandom);
      sel      = 3'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_zero"}, int'(zero), 0);
    chk({tag, "_carry"}, int'(carry), 0);
  endtask

  task automatic clear_model();
    q.delete();
    held.res = 0;
    held.z   = 0;
    held.c   = 0;
    held.due = 0;
  endtask

  // Monitor: each output cycle either retires the oldest due entry or must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check_reset_outputs("in_reset");
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("latency", cyc, e.due);
      chk("out_valid", int'(out_valid), 1);
      chk("result", int'(result), e.res);
      chk("zero", int'(zero), e.z);
      chk("carry", int'(carry), e.c);
      held = e;
    end else begin
      chk("idle_valid", int'(out_valid), 0);
      chk("hold_result", int'(result), held.res);
      chk("hold_zero", int'(zero), held.z);
      chk("hold_carry", int'(carry), held.c);
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sel      = '0;
    clear_model();
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Every opcode back-to-back with a=3, b=2.
    for (int s = 0; s < 8; s++) issue(3, 2, s);

    // Boundary operands.
    issue(15, 15, 0);
    issue(0, 1, 1);
    issue(5, 5, 1);
    issue(15, 0, 2);
    issue(0, 1, 7);
    issue(15, 0, 5);
    issue(8, 0, 2);
    issue(2, 3, 1);

    // Single capture then three idle cycles: outputs must hold.
    issue(3, 2, 0);
    idle(3);

    // Random traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    // Asynchronous reset mid-cycle after a capture left non-zero state.
    issue(9, 4, 0);
    idle(1);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset_outputs("async_rst");
    idle(2);
    #2;
    rst_n = 1'b1;
    idle(2);

    // Reset falls in the same cycle as a valid request: nothing may appear.
    issue(7, 1, 0);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset_outputs("rst_midop");
    idle(2);
    #2;
    rst_n = 1'b1;
    idle(3);

    // First capture after release behaves normally.
    issue(6, 7, 1);
    issue(12, 10, 6);
    idle(3);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
